bin2bcd_seq: RTL



---
 rtl/bin2bcd_seq.sv | 91 +++++++++
 1 files changed

// File: rtl/bin2bcd_seq.sv
// Iterative 32-bit binary to 8-digit packed BCD converter (double dabble, one bit per clock).
// The result and overflow flag are held until the next conversion completes.
//
// state | meaning
// IDLE  | waiting for start; bcd/ovf hold the last result
// SHIFT | one correct-and-shift step per clock, 32 steps total
module bin2bcd_seq (
   input  logic        clk,
   input  logic        reset,
   input  logic        start,
   input  logic [31:0] bin,
   output logic        busy,
   output logic        done,
   output logic [31:0] bcd,
   output logic        ovf
);

   typedef enum logic {IDLE = 1'b0, SHIFT = 1'b1} state_t;

   state_t      state, state_nxt;
   logic [31:0] shreg, shreg_nxt;
   logic [39:0] scratch, scratch_nxt;
   logic [39:0] corr;
   logic [5:0]  cnt, cnt_nxt;
   logic [31:0] bcd_nxt;
   logic        ovf_nxt;
   logic        done_nxt;

   always_ff @(posedge clk) begin
      if (reset) begin
         state   <= IDLE;
         shreg   <= '0;
         scratch <= '0;
         cnt     <= '0;
         bcd     <= '0;
         ovf     <= 1'b0;
         done    <= 1'b0;
      end else begin
         state   <= state_nxt;
         shreg   <= shreg_nxt;
         scratch <= scratch_nxt;
         cnt     <= cnt_nxt;
         bcd     <= bcd_nxt;
         ovf     <= ovf_nxt;
         done    <= done_nxt;
      end
   end

   always_comb begin
      state_nxt   = state;
      shreg_nxt   = shreg;
      scratch_nxt = scratch;
      cnt_nxt     = cnt;
      bcd_nxt     = bcd;
      ovf_nxt     = ovf;
      done_nxt    = 1'b0;
      corr        = '0;

      // Ten independent digit adders; a carry never leaves its digit.
      for (int d = 0; d < 10; d++) begin
         corr[4*d +: 4] = (scratch[4*d +: 4] >= 4'd5) ? scratch[4*d +: 4] + 4'd3
                                                     : scratch[4*d +: 4];
      end

      case (state)
         IDLE: begin
            if (start) begin
               shreg_nxt   = bin;
               scratch_nxt = '0;
               cnt_nxt     = '0;
               state_nxt   = SHIFT;
            end
         end
         SHIFT: begin
            scratch_nxt = {corr[38:0], shreg[31]};
            shreg_nxt   = {shreg[30:0], 1'b0};
            cnt_nxt     = cnt + 6'd1;
            if (cnt == 6'd31) begin
               bcd_nxt   = scratch_nxt[31:0];
               ovf_nxt   = |scratch_nxt[39:32];
               done_nxt  = 1'b1;
               state_nxt = IDLE;
            end
         end
         default: state_nxt = IDLE;
      endcase
   end

   assign busy = (state == SHIFT);

endmodule
